mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one external memory bus between the CPU's instruction-fetch port and its data (load/store) port, for single-memory boards.
- Sits between the CPU core's rom_* / ram_* interfaces and the bus or SRAM controller.
- Runs one transaction at a time through a registered request/ack handshake with a timeout.
- Supplies a stall request that the pipeline stall controller ORs into its stall logic.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT, 255, maximum bus cycles to wait for bus_ack_i (0 = wait forever).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_ce_i  in  1  fetch request, held stable until if_ready_o
- if_addr_i  in  ADDR_W  fetch address
- if_data_o  out  DATA_W  fetched instruction, valid when if_ready_o=1
- if_ready_o  out  1  one-cycle completion pulse for fetch
- d_ce_i  in  1  data request, held stable until d_ready_o
- d_we_i  in  1  1 = write, 0 = read
- d_sel_i  in  4  byte enables
- d_addr_i  in  ADDR_W  data address
- d_data_i  in  DATA_W  write data
- d_data_o  out  DATA_W  read data, valid when d_ready_o=1
- d_ready_o  out  1  one-cycle completion pulse for data
- bus_ce_o  out  1  bus request, registered
- bus_we_o  out  1  bus write, registered
- bus_sel_o  out  4  bus byte enables, registered
- bus_addr_o  out  ADDR_W  bus address, registered
- bus_data_o  out  DATA_W  bus write data, registered
- bus_data_i  in  DATA_W  bus read data, sampled on ack
- bus_ack_i  in  1  bus transfer complete
- err_o  out  1  one-cycle pulse when a transaction times out
- stallreq_o  out  1  pipeline stall request, combinational
- grant_o  out  2  current owner: 00 none, 01 fetch, 10 data

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; last_grant = fetch; timeout counter = 0.
  - All outputs go to 0, including the data outputs and grant_o.
  - An outstanding transaction is abandoned, bus_ce_o drops on the next edge, and any later ack seen in IDLE is ignored.
- State IDLE:
  - Evaluates d_ce_i and if_ce_i.
  - Only one request pending: grant it.
  - Both pending: grant data unless last_grant == data, in which case grant fetch (alternation under contention).
  - On a grant: latch address/we/sel/data into the bus_* registers, set bus_ce_o=1, update last_grant and grant_o, clear the counter, then go to BUS.
  - A fetch grant always drives bus_we_o=0 and bus_sel_o=4'b1111.
- State BUS:
  - bus_* outputs are held stable.
  - bus_ack_i=1: capture bus_data_i into if_data_o (fetch) or into d_data_o (data read); a data write leaves d_data_o unchanged. Drop bus_ce_o and go to RESP.
  - No ack: increment the counter.
  - TIMEOUT != 0 and counter == TIMEOUT-1 with no ack: drop bus_ce_o, force the captured data to 0, pulse err_o during RESP, and go to RESP.
- State RESP:
  - Exactly one cycle.
  - The owner's ready output is 1; grant_o is still valid. Go to IDLE, where grant_o becomes 00.
  - Requests are not sampled in RESP, so a request still held during its own ready cycle is never issued twice.
- Latency: request seen in IDLE at cycle 0, bus_ce_o=1 at cycle 1, ack earliest at cycle 1, ready at cycle 2, next grant evaluated at cycle 3.
- Throughput: one transaction per 3 cycles at minimum.
- stallreq_o = (if_ce_i & ~if_ready_o) | (d_ce_i & ~d_ready_o).
- The requester must keep its request fields stable while its ce is high and ready is low. Behaviour is undefined if a held request changes.
- Ack in IDLE or RESP is ignored.
- At most one ready output is high in any cycle.

Test Plan:
- Reset then single fetch: if_addr_i=0x100, ack in the cycle bus_ce_o rises, bus_data_i=0x24020005 -> bus_addr_o=0x100, bus_we_o=0, if_ready_o pulses at cycle 2, if_data_o=0x24020005, stallreq_o=1 for cycles 0-1.
- Contention: if_ce_i and d_ce_i (read 0x8000) asserted together and held -> data served first, then fetch, then data again; grant_o sequence 10,01,10; never two readies in the same cycle.
- Data write: d_we_i=1, d_sel_i=4'b0011, d_data_i=0xDEADBEEF, ack delayed 4 cycles -> bus fields stable for 5 cycles, d_ready_o pulses once, d_data_o unchanged.
- Timeout with TIMEOUT=8, no ack -> bus_ce_o high exactly 8 cycles, then err_o and d_ready_o pulse together with d_data_o=0; state returns to IDLE.
- Reset mid-transaction: rst at cycle 2 of a pending fetch -> next edge bus_ce_o=0 and grant_o=00; an ack at cycle 4 produces no ready pulse.
- Late ack after timeout (arrives in RESP/IDLE) -> ignored; the next request proceeds normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the CPU fetch/data ports, the external memory bus and the arbiter.
// The slave modport is the arbiter's view; the master modport is the CPU/bus side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_ce_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_ready_o;

    logic              d_ce_i;
    logic              d_we_i;
    logic [3:0]        d_sel_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_data_i;
    logic [DATA_W-1:0] d_data_o;
    logic              d_ready_o;

    logic              bus_ce_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_data_o;
    logic [DATA_W-1:0] bus_data_i;
    logic              bus_ack_i;

    logic              err_o;
    logic              stallreq_o;
    logic [1:0]        grant_o;

    modport slave (
        input  if_ce_i, if_addr_i,
        input  d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
        input  bus_data_i, bus_ack_i,
        output if_data_o, if_ready_o,
        output d_data_o, d_ready_o,
        output bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
        output err_o, stallreq_o, grant_o
    );

    modport master (
        output if_ce_i, if_addr_i,
        output d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
        output bus_data_i, bus_ack_i,
        input  if_data_o, if_ready_o,
        input  d_data_o, d_ready_o,
        input  bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
        input  err_o, stallreq_o, grant_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and data access, one registered
// transaction at a time, alternating owners under contention and timing out silent slaves.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave mif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE  = 2'b00;
    localparam logic [1:0] GNT_FETCH = 2'b01;
    localparam logic [1:0] GNT_DATA  = 2'b10;

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [1:0]        grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_ce_q, bus_ce_d;
    logic              bus_we_q, bus_we_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;
    logic              err_q, err_d;

    logic if_ready;
    logic d_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        bus_ce_d     = bus_ce_q;
        bus_we_d     = bus_we_q;
        bus_sel_d    = bus_sel_q;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        if_data_d    = if_data_q;
        d_data_d     = d_data_q;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d = GNT_NONE;
                // Data wins a tie unless it also won the previous grant.
                if (mif.d_ce_i && (!mif.if_ce_i || last_grant_q != GNT_DATA)) begin
                    grant_d      = GNT_DATA;
                    last_grant_d = GNT_DATA;
                    bus_we_d     = mif.d_we_i;
                    bus_sel_d    = mif.d_sel_i;
                    bus_addr_d   = mif.d_addr_i;
                    bus_data_d   = mif.d_data_i;
                    bus_ce_d     = 1'b1;
                    cnt_d        = '0;
                    state_d      = BUS;
                end else if (mif.if_ce_i) begin
                    grant_d      = GNT_FETCH;
                    last_grant_d = GNT_FETCH;
                    bus_we_d     = 1'b0;
                    bus_sel_d    = 4'b1111;
                    bus_addr_d   = mif.if_addr_i;
                    bus_data_d   = '0;
                    bus_ce_d     = 1'b1;
                    cnt_d        = '0;
                    state_d      = BUS;
                end
            end
            BUS: begin
                if (mif.bus_ack_i) begin
                    if (grant_q == GNT_FETCH) begin
                        if_data_d = mif.bus_data_i;
                    end else if (!bus_we_q) begin
                        d_data_d = mif.bus_data_i;
                    end
                    bus_ce_d = 1'b0;
                    state_d  = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    // A timed-out transfer returns zero so stale data is never mistaken for a result.
                    if (grant_q == GNT_FETCH) begin
                        if_data_d = '0;
                    end else begin
                        d_data_d = '0;
                    end
                    bus_ce_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                grant_d = GNT_NONE;
                state_d = IDLE;
            end
            default: begin
                grant_d  = GNT_NONE;
                bus_ce_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_FETCH;
            grant_q      <= GNT_NONE;
            cnt_q        <= '0;
            bus_ce_q     <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= '0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            if_data_q    <= '0;
            d_data_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            bus_ce_q     <= bus_ce_d;
            bus_we_q     <= bus_we_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            if_data_q    <= if_data_d;
            d_data_q     <= d_data_d;
            err_q        <= err_d;
        end
    end

    // Ready is decoded from registered state, so it is a clean single-cycle pulse in RESP.
    assign if_ready = (state_q == RESP) && (grant_q == GNT_FETCH);
    assign d_ready  = (state_q == RESP) && (grant_q == GNT_DATA);

    assign mif.if_ready_o = if_ready;
    assign mif.d_ready_o  = d_ready;
    assign mif.if_data_o  = if_data_q;
    assign mif.d_data_o   = d_data_q;
    assign mif.bus_ce_o   = bus_ce_q;
    assign mif.bus_we_o   = bus_we_q;
    assign mif.bus_sel_o  = bus_sel_q;
    assign mif.bus_addr_o = bus_addr_q;
    assign mif.bus_data_o = bus_data_q;
    assign mif.err_o      = err_q;
    assign mif.grant_o    = grant_q;
    assign mif.stallreq_o = (mif.if_ce_i & ~if_ready) | (mif.d_ce_i & ~d_ready);

endmodule
